// File: rtl/neuron_pkg.sv
// Shared types and constants for time-multiplexed neuron layer controllers.
// Coefficient field layout per neuron: three weights followed by three biases.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int F_W1     = 0;
    localparam int F_W2     = 1;
    localparam int F_W3     = 2;
    localparam int F_B1     = 3;
    localparam int F_B2     = 4;
    localparam int F_B3     = 5;
    localparam int N_FIELDS = 6;

    // Flat config address of one coefficient of one neuron.
    function automatic int cfg_index(input int neuron, input int field);
        return neuron * N_FIELDS + field;
    endfunction

endpackage

// File: rtl/neuron_wmem.sv
// Per-neuron weight/bias register file: flat write port, six-word read of one neuron.
// Out-of-range write addresses are ignored.
module neuron_wmem
    import neuron_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_NEURON = 4,
    parameter int AW       = $clog2(N_FIELDS * N_NEURON),
    parameter int IW       = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [AW-1:0]                    addr,
    input  logic [WIDTH-1:0]                 wdata,
    input  logic [IW-1:0]                    rd_idx,
    output logic [N_FIELDS-1:0][WIDTH-1:0]   rd_words
);

    localparam int DEPTH = N_FIELDS * N_NEURON;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             addr_ok;
    logic [AW-1:0]    rd_base;

    // The address field can encode more words than exist when DEPTH is not a power of two.
    assign addr_ok = ({1'b0, addr} < (AW + 1)'(DEPTH));

    // NOTE: every word is reset, not just control state -- a reset mid-run must leave
    // no stale coefficients behind, so this cannot be an uninitialised RAM.
    // NOTE: sequential state uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && addr_ok) begin
            mem[addr] <= wdata;
        end
    end

    assign rd_base = AW'(rd_idx) * AW'(N_FIELDS);

    for (genvar f = 0; f < N_FIELDS; f++) begin : g_rd
        assign rd_words[f] = mem[rd_base + AW'(f)];
    end

endmodule

// File: rtl/neuron_layer_sched.sv
// Layer scheduler: drives one shared combinational 3-input neuron once per cycle for
// each of N_NEURON logical neurons and collects the results into an output vector.
module neuron_layer_sched
    import neuron_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_NEURON = 4,
    parameter int AW       = $clog2(N_FIELDS * N_NEURON)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_a1,
    input  logic [WIDTH-1:0]            in_a2,
    input  logic [WIDTH-1:0]            in_a3,
    input  logic                        cfg_we,
    input  logic [AW-1:0]               cfg_addr,
    input  logic [WIDTH-1:0]            cfg_wdata,
    output logic [WIDTH-1:0]            n_a1,
    output logic [WIDTH-1:0]            n_a2,
    output logic [WIDTH-1:0]            n_a3,
    output logic [WIDTH-1:0]            n_w1,
    output logic [WIDTH-1:0]            n_w2,
    output logic [WIDTH-1:0]            n_w3,
    output logic [WIDTH-1:0]            n_b1,
    output logic [WIDTH-1:0]            n_b2,
    output logic [WIDTH-1:0]            n_b3,
    input  logic [WIDTH-1:0]            n_y,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_NEURON*WIDTH-1:0]   out_y,
    output logic                        busy
);

    localparam int IW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;

    state_t                          state;
    state_t                          state_nxt;
    logic [IW-1:0]                   idx;
    logic [2:0][WIDTH-1:0]           a_q;
    logic [N_FIELDS-1:0][WIDTH-1:0]  coef;
    logic                            accept;
    logic                            last;
    logic                            wmem_we;

    assign accept  = in_valid && in_ready;
    assign last    = (idx == IW'(N_NEURON - 1));
    // Coefficients may only change between runs so a vector never sees a mixed set.
    assign wmem_we = cfg_we && (state == IDLE);

    neuron_wmem #(
        .WIDTH    (WIDTH),
        .N_NEURON (N_NEURON),
        .AW       (AW),
        .IW       (IW)
    ) u_wmem (
        .clk      (clk),
        .rst      (rst),
        .we       (wmem_we),
        .addr     (cfg_addr),
        .wdata    (cfg_wdata),
        .rd_idx   (idx),
        .rd_words (coef)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default assignment first; any path that skipped state_nxt would infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        n_a1      = '0;
        n_a2      = '0;
        n_a3      = '0;
        n_w1      = '0;
        n_w2      = '0;
        n_w3      = '0;
        n_b1      = '0;
        n_b2      = '0;
        n_b3      = '0;
        if (state == RUN) begin
            n_a1 = a_q[0];
            n_a2 = a_q[1];
            n_a3 = a_q[2];
            n_w1 = coef[F_W1];
            n_w2 = coef[F_W2];
            n_w3 = coef[F_W3];
            n_b1 = coef[F_B1];
            n_b2 = coef[F_B2];
            n_b3 = coef[F_B3];
        end
    end

    // Activation latch, neuron index and result buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            a_q   <= '0;
            out_y <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q <= {in_a3, in_a2, in_a1};
                        idx <= '0;
                    end
                end
                RUN: begin
                    out_y[int'(idx)*WIDTH +: WIDTH] <= n_y;
                    if (!last) begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Directed bench for neuron_layer_sched with a multiply-accumulate stub as the shared neuron.
// Expected vectors are worked out by hand from the coefficients each test loads.
module tb_neuron_layer_sched;
    import neuron_pkg::*;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int AW    = 5;

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   in_a1, in_a2, in_a3;
    logic                      cfg_we;
    logic [AW-1:0]             cfg_addr;
    logic [WIDTH-1:0]          cfg_wdata;
    logic signed [WIDTH-1:0]   n_a1, n_a2, n_a3;
    logic signed [WIDTH-1:0]   n_w1, n_w2, n_w3;
    logic signed [WIDTH-1:0]   n_b1, n_b2, n_b3;
    logic signed [WIDTH-1:0]   n_y;
    logic                      out_valid;
    logic                      out_ready;
    logic [N*WIDTH-1:0]        out_y;
    logic                      busy;

    int passed = 0;
    int total  = 0;

    neuron_layer_sched #(
        .WIDTH    (WIDTH),
        .N_NEURON (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a1     (in_a1),
        .in_a2     (in_a2),
        .in_a3     (in_a3),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .n_a1      (n_a1),
        .n_a2      (n_a2),
        .n_a3      (n_a3),
        .n_w1      (n_w1),
        .n_w2      (n_w2),
        .n_w3      (n_w3),
        .n_b1      (n_b1),
        .n_b2      (n_b2),
        .n_b3      (n_b3),
        .n_y       (n_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    assign n_y = n_a1 * n_w1 + n_a2 * n_w2 + n_a3 * n_w3 + n_b1 + n_b2 + n_b3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N*WIDTH-1:0] pack4(input int y0, input int y1, input int y2, input int y3);
        pack4 = {WIDTH'(y3), WIDTH'(y2), WIDTH'(y1), WIDTH'(y0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(addr);
        cfg_wdata = WIDTH'(data);
        tick();
        cfg_we    = 1'b0;
    endtask

    // Presents a vector (optionally with a same-cycle config write) and returns after the accept edge.
    task automatic send_cfg(input int a1, input int a2, input int a3,
                            input logic we, input int addr, input int data);
        int g;
        g = 0;
        while (!in_ready && g < 20) begin
            tick();
            g++;
        end
        total++;
        if (!in_ready) $display("FAIL send_in_ready_timeout: in_ready=%b required 1", in_ready);
        else passed++;
        in_a1     = WIDTH'(a1);
        in_a2     = WIDTH'(a2);
        in_a3     = WIDTH'(a3);
        in_valid  = 1'b1;
        cfg_we    = we;
        cfg_addr  = AW'(addr);
        cfg_wdata = WIDTH'(data);
        tick();
        in_valid  = 1'b0;
        cfg_we    = 1'b0;
    endtask

    task automatic send(input int a1, input int a2, input int a3);
        send_cfg(a1, a2, a3, 1'b0, 0, 0);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (!out_valid) $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
        else passed++;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a1     = '0;
        in_a2     = '0;
        in_a3     = '0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready_held: got %b required 0", in_ready);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else passed++;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_flags: out_valid=%b busy=%b required 0 0", out_valid, busy);
        else passed++;
        total++;
        if (out_y !== '0) $display("FAIL reset_out_y: got %h required 0", out_y);
        else passed++;
        total++;
        if (n_a1 !== '0 || n_w1 !== '0 || n_b3 !== '0) $display("FAIL reset_n_bus: a1=%0d w1=%0d b3=%0d required 0", n_a1, n_w1, n_b3);
        else passed++;
    endtask

    task automatic test_basic();
        int lat;
        for (int k = 0; k < N; k++) cfg_write(cfg_index(k, F_W1), k + 1);
        send(10, 0, 0);
        lat = 1;
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL basic_run_flags: busy=%b in_ready=%b required 1 0", busy, in_ready);
        else passed++;
        total++;
        if (n_a1 !== 32'sd10 || n_w1 !== 32'sd1) $display("FAIL basic_first_drive: n_a1=%0d n_w1=%0d required 10 1", n_a1, n_w1);
        else passed++;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 5) $display("FAIL basic_latency: got %0d cycles required 5", lat);
        else passed++;
        total++;
        if (out_y !== pack4(10, 20, 30, 40)) $display("FAIL basic_out_y: got %h required %h", out_y, pack4(10, 20, 30, 40));
        else passed++;
        total++;
        if (n_w1 !== '0) $display("FAIL basic_done_n_bus: n_w1=%0d required 0", n_w1);
        else passed++;
        release_out();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_release: out_valid=%b busy=%b required 0 0", out_valid, busy);
        else passed++;
    endtask

    task automatic test_hold();
        logic [N*WIDTH-1:0] exp;
        send(3, 0, 0);
        wait_out();
        exp = pack4(3, 6, 9, 12);
        in_a1    = 32'sd5;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if ({out_valid, in_ready, busy} !== 3'b101 || out_y !== exp)
                $display("FAIL hold_cycle%0d: valid/ready/busy=%b out_y=%h required 101 %h", c, {out_valid, in_ready, busy}, out_y, exp);
            else passed++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL hold_no_bypass: busy=%b in_ready=%b required 0 1", busy, in_ready);
        else passed++;
        tick();
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL hold_accept_after_idle: busy=%b required 1", busy);
        else passed++;
        wait_out();
        total++;
        if (out_y !== pack4(5, 10, 15, 20)) $display("FAIL hold_second_vector: got %h required %h", out_y, pack4(5, 10, 15, 20));
        else passed++;
        release_out();
    endtask

    task automatic test_cfg_drop();
        send(0, 0, 0);
        tick();
        cfg_write(cfg_index(0, F_B1), 7);
        wait_out();
        total++;
        if (out_y !== '0) $display("FAIL cfg_run_write_run: got %h required 0", out_y);
        else passed++;
        cfg_write(cfg_index(0, F_B2), 50);
        release_out();
        send(0, 0, 0);
        wait_out();
        total++;
        if (out_y !== '0) $display("FAIL cfg_dropped: got %h required 0", out_y);
        else passed++;
        release_out();
        cfg_write(cfg_index(0, F_B1), 7);
        send_cfg(0, 0, 0, 1'b1, cfg_index(1, F_B1), 9);
        wait_out();
        total++;
        if (out_y !== pack4(7, 9, 0, 0)) $display("FAIL cfg_idle_write: got %h required %h", out_y, pack4(7, 9, 0, 0));
        else passed++;
        release_out();
    endtask

    task automatic test_reset_mid();
        send(10, 0, 0);
        tick();
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, busy, in_ready} !== 3'b000) $display("FAIL rstmid_flags: valid/busy/ready=%b required 000", {out_valid, busy, in_ready});
        else passed++;
        total++;
        if (out_y !== '0 || n_w1 !== '0) $display("FAIL rstmid_clear: out_y=%h n_w1=%0d required 0 0", out_y, n_w1);
        else passed++;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b required 1", in_ready);
        else passed++;
        send(10, 1, 1);
        wait_out();
        total++;
        if (out_y !== '0) $display("FAIL rstmid_weights_cleared: got %h required 0", out_y);
        else passed++;
        release_out();
    endtask

    task automatic test_back_to_back();
        int exp_y [3][N];
        int av [3][3];
        int acc_cyc [3];
        int acc_n, done_n, cyc;
        logic was_busy;
        av = '{'{1, 2, 3}, '{-4, 5, 0}, '{7, -1, -2}};
        exp_y = '{'{8, 8, 8, 8}, '{-3, -11, -19, -27}, '{4, 13, 22, 31}};
        for (int k = 0; k < N; k++) begin
            cfg_write(cfg_index(k, F_W1), k + 1);
            cfg_write(cfg_index(k, F_W2), -k);
            cfg_write(cfg_index(k, F_W3), 2);
            cfg_write(cfg_index(k, F_B1), k);
            cfg_write(cfg_index(k, F_B2), 0);
            cfg_write(cfg_index(k, F_B3), 1);
        end
        acc_n  = 0;
        done_n = 0;
        cyc    = 0;
        in_a1  = WIDTH'(av[0][0]);
        in_a2  = WIDTH'(av[0][1]);
        in_a3  = WIDTH'(av[0][2]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        was_busy  = busy;
        while (done_n < 3 && cyc < 80) begin
            tick();
            cyc++;
            if (busy && !was_busy && acc_n < 3) begin
                acc_cyc[acc_n] = cyc;
                acc_n++;
                if (acc_n < 3) begin
                    in_a1 = WIDTH'(av[acc_n][0]);
                    in_a2 = WIDTH'(av[acc_n][1]);
                    in_a3 = WIDTH'(av[acc_n][2]);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                total++;
                if (out_y !== pack4(exp_y[done_n][0], exp_y[done_n][1], exp_y[done_n][2], exp_y[done_n][3]))
                    $display("FAIL b2b_vector%0d: got %h required %h", done_n, out_y,
                             pack4(exp_y[done_n][0], exp_y[done_n][1], exp_y[done_n][2], exp_y[done_n][3]));
                else passed++;
                done_n++;
            end
            was_busy = busy;
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (done_n !== 3 || acc_n !== 3) $display("FAIL b2b_count: results=%0d accepts=%0d required 3 3", done_n, acc_n);
        else passed++;
        if (acc_n == 3) begin
            total++;
            if (acc_cyc[1] - acc_cyc[0] !== 6 || acc_cyc[2] - acc_cyc[1] !== 6)
                $display("FAIL b2b_interval: got %0d,%0d cycles required 6,6", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            else passed++;
        end
    endtask

    task automatic test_range_neg();
        cfg_write(24, 99);
        cfg_write(31, 99);
        send(1, 1, 1);
        wait_out();
        total++;
        if (out_y !== pack4(4, 5, 6, 7)) $display("FAIL range_ignored: got %h required %h", out_y, pack4(4, 5, 6, 7));
        else passed++;
        release_out();
        for (int k = 0; k < N; k++) begin
            for (int f = 0; f < N_FIELDS; f++) cfg_write(cfg_index(k, f), (f == F_W1) ? 5 : 0);
        end
        send(-3, 0, 0);
        wait_out();
        total++;
        if (out_y !== pack4(-15, -15, -15, -15)) $display("FAIL negative_values: got %h required %h", out_y, pack4(-15, -15, -15, -15));
        else passed++;
        release_out();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_cfg_drop();
        test_reset_mid();
        test_back_to_back();
        test_range_neg();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
